// File: rtl/stmm_sched.sv
`default_nettype none
// ============================================================================
//  Module   : stmm_sched
//  Purpose  : In-order hazard-checked command scheduler for the StMM
//             execution units. Buffers FETCH/EXEC commands in a small FIFO
//             and issues the head only when the shared fetcher is free, the
//             target sub-unit is not executing, and (for EXEC) its weights
//             are loaded.
//  Ports    : clk, rst             - clock, synchronous active-high reset
//             cmd_valid/ready      - command handshake
//             cmd_op/sub/addr      - 0=FETCH 1=EXEC, target sub-unit, address
//             eu_fetch/eu_exec     - one-cycle start pulses
//             eu_sub_idx           - sub-unit of the latest pulse (held)
//             eu_fetch_addr        - address of the latest fetch (held)
//             fetch_done           - fetcher completion pulse
//             exec_done            - per-sub-unit completion pulses
//             sub_loaded/sub_busy  - per-sub-unit status
//             fetch_busy           - fetch in flight
//             err_unloaded         - EXEC to an unloaded sub-unit was dropped
//             idle                 - nothing queued or in flight
//  Revision : 1.0  initial release
// ============================================================================
module stmm_sched #(
  parameter int SUB_NUM      = 4,
  parameter int FETCH_ADDR_W = 32,
  parameter int DEPTH        = 4,
  localparam int SUB_W       = (SUB_NUM > 1) ? $clog2(SUB_NUM) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_op,
  input  logic [SUB_W-1:0]        cmd_sub,
  input  logic [FETCH_ADDR_W-1:0] cmd_addr,
  output logic                    eu_fetch,
  output logic                    eu_exec,
  output logic [SUB_W-1:0]        eu_sub_idx,
  output logic [FETCH_ADDR_W-1:0] eu_fetch_addr,
  input  logic                    fetch_done,
  input  logic [SUB_NUM-1:0]      exec_done,
  output logic [SUB_NUM-1:0]      sub_loaded,
  output logic [SUB_NUM-1:0]      sub_busy,
  output logic                    fetch_busy,
  output logic                    err_unloaded,
  output logic                    idle
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  // --------------------------------------------------------------------------
  // Command FIFO
  // --------------------------------------------------------------------------
  logic                    fifo_op   [DEPTH];
  logic [SUB_W-1:0]        fifo_sub  [DEPTH];
  logic [FETCH_ADDR_W-1:0] fifo_addr [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_next;
  logic             full;
  logic             push;
  logic             pop;

  logic                    head_valid;
  logic                    head_op;
  logic [SUB_W-1:0]        head_sub;
  logic [FETCH_ADDR_W-1:0] head_addr;

  logic [SUB_W-1:0] fetch_sub;

  // Full is a register, so a pop in the same cycle never frees a slot
  // for a simultaneous push.
  assign cmd_ready  = !full;
  assign push       = cmd_valid && !full;
  assign head_valid = (count != '0);
  assign head_op    = fifo_op[rd_ptr];
  assign head_sub   = fifo_sub[rd_ptr];
  assign head_addr  = fifo_addr[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wr_ptr]   <= cmd_op;
      fifo_sub[wr_ptr]  <= cmd_sub;
      fifo_addr[wr_ptr] <= cmd_addr;
    end
  end

  // --------------------------------------------------------------------------
  // Issue decision for the head entry (registered state only)
  // --------------------------------------------------------------------------
  logic fetch_pending;
  logic issue_fetch;
  logic issue_exec;
  logic drop_exec;

  // The head EXEC targets the sub-unit currently being fetched: it waits
  // for the fetch rather than being rejected as unloaded.
  assign fetch_pending = fetch_busy && (fetch_sub == head_sub);

  always_comb begin
    issue_fetch = 1'b0;
    issue_exec  = 1'b0;
    drop_exec   = 1'b0;
    if (head_valid) begin
      if (!head_op) begin
        issue_fetch = !fetch_busy && !sub_busy[head_sub];
      end else if (fetch_pending) begin
        issue_exec = 1'b0;
      end else if (!sub_loaded[head_sub]) begin
        drop_exec = 1'b1;
      end else begin
        issue_exec = !sub_busy[head_sub];
      end
    end
  end

  assign pop = issue_fetch || issue_exec || drop_exec;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + (PTR_W + 1)'(1);
      2'b01:   count_next = count - (PTR_W + 1)'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
      full  <= (count_next == FULL_CNT);
    end
  end

  // --------------------------------------------------------------------------
  // Execution-unit state and issue pulses
  // --------------------------------------------------------------------------
  // Completions are applied before issues; the hazard checks guarantee an
  // issue never targets the same flag a completion is clearing this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_busy    <= 1'b0;
      fetch_sub     <= '0;
      sub_loaded    <= '0;
      sub_busy      <= '0;
      eu_fetch      <= 1'b0;
      eu_exec       <= 1'b0;
      eu_sub_idx    <= '0;
      eu_fetch_addr <= '0;
      err_unloaded  <= 1'b0;
    end else begin
      eu_fetch     <= 1'b0;
      eu_exec      <= 1'b0;
      err_unloaded <= drop_exec;

      if (fetch_done && fetch_busy) begin
        fetch_busy            <= 1'b0;
        sub_loaded[fetch_sub] <= 1'b1;
      end

      for (int i = 0; i < SUB_NUM; i++) begin
        if (exec_done[i] && sub_busy[i]) sub_busy[i] <= 1'b0;
      end

      if (issue_fetch) begin
        fetch_busy           <= 1'b1;
        fetch_sub            <= head_sub;
        sub_loaded[head_sub] <= 1'b0;
        eu_fetch             <= 1'b1;
        eu_sub_idx           <= head_sub;
        eu_fetch_addr        <= head_addr;
      end

      if (issue_exec) begin
        sub_busy[head_sub] <= 1'b1;
        eu_exec            <= 1'b1;
        eu_sub_idx         <= head_sub;
      end
    end
  end

  assign idle = !head_valid && !fetch_busy && (sub_busy == '0);

endmodule
`default_nettype wire

// File: tb/tb_stmm_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stmm_sched
//  Purpose  : Self-checking bench for stmm_sched: a per-cycle vector table
//             for reset, single fetch, unloaded exec and fetch-then-exec,
//             followed by hand-written multi-cycle sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_stmm_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_op = 1'b0;
  logic [1:0]  cmd_sub = 2'd0;
  logic [31:0] cmd_addr = 32'h0;
  logic        eu_fetch;
  logic        eu_exec;
  logic [1:0]  eu_sub_idx;
  logic [31:0] eu_fetch_addr;
  logic        fetch_done = 1'b0;
  logic [3:0]  exec_done = 4'b0;
  logic [3:0]  sub_loaded;
  logic [3:0]  sub_busy;
  logic        fetch_busy;
  logic        err_unloaded;
  logic        idle;

  int errors = 0;
  int checks = 0;

  stmm_sched #(.SUB_NUM(4), .FETCH_ADDR_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_sub(cmd_sub), .cmd_addr(cmd_addr),
    .eu_fetch(eu_fetch), .eu_exec(eu_exec), .eu_sub_idx(eu_sub_idx),
    .eu_fetch_addr(eu_fetch_addr),
    .fetch_done(fetch_done), .exec_done(exec_done),
    .sub_loaded(sub_loaded), .sub_busy(sub_busy), .fetch_busy(fetch_busy),
    .err_unloaded(err_unloaded), .idle(idle)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic op, input logic [1:0] s, input logic [31:0] a);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_sub   = s;
    cmd_addr  = a;
    tick();
    cmd_valid = 1'b0;
  endtask

  // One record per cycle: inputs driven for the coming edge, expected
  // outputs as seen just before those inputs are applied.
  typedef struct {
    logic        rst, v, op;
    logic [1:0]  s;
    logic [31:0] a;
    logic        fd;
    logic [3:0]  ed;
    logic        chk, rdy, f, x;
    logic [1:0]  idx;
    logic [31:0] fa;
    logic        err;
    logic [3:0]  ld, bz;
    logic        fb, idl;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic r, input logic v, input logic op, input logic [1:0] s,
    input logic [31:0] a, input logic fd, input logic [3:0] ed,
    input logic chk, input logic rdy, input logic f, input logic x,
    input logic [1:0] idx, input logic [31:0] fa, input logic err,
    input logic [3:0] ld, input logic [3:0] bz, input logic fb, input logic idl);
    vec_t t;
    t.rst = r;  t.v = v;   t.op = op; t.s = s;   t.a = a;   t.fd = fd; t.ed = ed;
    t.chk = chk; t.rdy = rdy; t.f = f; t.x = x; t.idx = idx; t.fa = fa;
    t.err = err; t.ld = ld; t.bz = bz; t.fb = fb; t.idl = idl;
    return t;
  endfunction

  initial begin
    //             rst   v     op    sub   addr          fd    ed       chk   rdy   fetch exec  idx   faddr         err   loaded   busy     fb    idle
    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    vecs[1]  = mk(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
    vecs[2]  = mk(1'b0, 1'b1, 1'b0, 2'd2, 32'h1000,     1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
    vecs[3]  = mk(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    vecs[4]  = mk(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 32'h1000,     1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
    vecs[5]  = mk(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 32'h1000,     1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
    vecs[6]  = mk(1'b0, 1'b1, 1'b1, 2'd1, 32'h0,        1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 32'h1000,     1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1);
    vecs[7]  = mk(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 32'h1000,     1'b0, 4'b0100, 4'b0000, 1'b0, 1'b0);
    vecs[8]  = mk(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 32'h1000,     1'b1, 4'b0100, 4'b0000, 1'b0, 1'b1);
    vecs[9]  = mk(1'b0, 1'b1, 1'b0, 2'd1, 32'h2000,     1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 32'h1000,     1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1);
    vecs[10] = mk(1'b0, 1'b1, 1'b1, 2'd1, 32'h0,        1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 32'h1000,     1'b0, 4'b0100, 4'b0000, 1'b0, 1'b0);
    vecs[11] = mk(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 32'h2000,     1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0);
    vecs[12] = mk(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 32'h2000,     1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0);
    vecs[13] = mk(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 32'h2000,     1'b0, 4'b0110, 4'b0000, 1'b0, 1'b0);
    vecs[14] = mk(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 32'h2000,     1'b0, 4'b0110, 4'b0010, 1'b0, 1'b0);
    vecs[15] = mk(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 32'h2000,     1'b0, 4'b0110, 4'b0010, 1'b0, 1'b0);
    vecs[16] = mk(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 32'h2000,     1'b0, 4'b0110, 4'b0000, 1'b0, 1'b1);

    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      if (vecs[k].chk) begin
        check($sformatf("v%0d cmd_ready", k),     cmd_ready,     vecs[k].rdy);
        check($sformatf("v%0d eu_fetch", k),      eu_fetch,      vecs[k].f);
        check($sformatf("v%0d eu_exec", k),       eu_exec,       vecs[k].x);
        check($sformatf("v%0d eu_sub_idx", k),    eu_sub_idx,    vecs[k].idx);
        check($sformatf("v%0d eu_fetch_addr", k), eu_fetch_addr, vecs[k].fa);
        check($sformatf("v%0d err_unloaded", k),  err_unloaded,  vecs[k].err);
        check($sformatf("v%0d sub_loaded", k),    sub_loaded,    vecs[k].ld);
        check($sformatf("v%0d sub_busy", k),      sub_busy,      vecs[k].bz);
        check($sformatf("v%0d fetch_busy", k),    fetch_busy,    vecs[k].fb);
        check($sformatf("v%0d idle", k),          idle,          vecs[k].idl);
      end
      rst        = vecs[k].rst;
      cmd_valid  = vecs[k].v;
      cmd_op     = vecs[k].op;
      cmd_sub    = vecs[k].s;
      cmd_addr   = vecs[k].a;
      fetch_done = vecs[k].fd;
      exec_done  = vecs[k].ed;
    end

    // Fresh start for the hand-written sequences.
    @(negedge clk);
    cmd_valid = 1'b0; fetch_done = 1'b0; exec_done = 4'b0000;
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // ---- Fetch serialization: FETCH 0 then FETCH 1 back to back ----
    push(1'b0, 2'd0, 32'hA000);
    push(1'b0, 2'd1, 32'hB000);
    check("ser first fetch", eu_fetch, 1'b1);
    check("ser first idx", eu_sub_idx, 2'd0);
    check("ser first addr", eu_fetch_addr, 32'hA000);
    tick();
    check("ser hold 1", eu_fetch, 1'b0);
    tick();
    check("ser hold 2", eu_fetch, 1'b0);
    check("ser fetch_busy", fetch_busy, 1'b1);
    fetch_done = 1'b1; tick(); fetch_done = 1'b0;
    check("ser no fetch on done edge", eu_fetch, 1'b0);
    tick();
    check("ser second fetch", eu_fetch, 1'b1);
    check("ser second idx", eu_sub_idx, 2'd1);
    check("ser second addr", eu_fetch_addr, 32'hB000);
    fetch_done = 1'b1; tick(); fetch_done = 1'b0;
    check("ser loaded", sub_loaded, 4'b0011);
    check("ser idle", idle, 1'b1);

    // ---- Exec hazards: EXEC 0, EXEC 1, EXEC 0 ----
    push(1'b1, 2'd0, 32'h0);
    push(1'b1, 2'd1, 32'h0);
    check("exh exec0 pulse", eu_exec, 1'b1);
    check("exh exec0 idx", eu_sub_idx, 2'd0);
    push(1'b1, 2'd0, 32'h0);
    check("exh exec1 pulse", eu_exec, 1'b1);
    check("exh exec1 idx", eu_sub_idx, 2'd1);
    tick();
    check("exh third stalls", eu_exec, 1'b0);
    check("exh busy", sub_busy, 4'b0011);
    exec_done = 4'b0001; tick(); exec_done = 4'b0000;
    check("exh no exec on done edge", eu_exec, 1'b0);
    tick();
    check("exh third pulse", eu_exec, 1'b1);
    check("exh third idx", eu_sub_idx, 2'd0);
    check("exh third busy", sub_busy, 4'b0011);
    exec_done = 4'b0011; tick(); exec_done = 4'b0000;
    tick();
    check("exh idle", idle, 1'b1);

    // ---- Fetch blocked while the same sub-unit executes ----
    push(1'b0, 2'd3, 32'h3000);
    tick();
    check("fde load fetch", eu_fetch, 1'b1);
    fetch_done = 1'b1; tick(); fetch_done = 1'b0;
    check("fde loaded3", sub_loaded, 4'b1011);
    push(1'b1, 2'd3, 32'h0);
    tick();
    check("fde exec3 pulse", eu_exec, 1'b1);
    check("fde exec3 idx", eu_sub_idx, 2'd3);
    check("fde busy3", sub_busy, 4'b1000);
    push(1'b0, 2'd3, 32'h3300);
    tick();
    check("fde blocked 1", eu_fetch, 1'b0);
    tick();
    check("fde blocked 2", eu_fetch, 1'b0);
    exec_done = 4'b1000; tick(); exec_done = 4'b0000;
    check("fde no fetch on done edge", eu_fetch, 1'b0);
    tick();
    check("fde fetch pulse", eu_fetch, 1'b1);
    check("fde fetch idx", eu_sub_idx, 2'd3);
    check("fde fetch addr", eu_fetch_addr, 32'h3300);
    check("fde loaded3 cleared", sub_loaded, 4'b0011);
    fetch_done = 1'b1; tick(); fetch_done = 1'b0;
    check("fde reloaded", sub_loaded, 4'b1011);

    // ---- Full FIFO behind a stalled head, then reset mid-fetch ----
    push(1'b0, 2'd0, 32'hC000);
    push(1'b0, 2'd1, 32'hC100);
    push(1'b0, 2'd2, 32'hC200);
    push(1'b0, 2'd3, 32'hC300);
    check("full ready at 3", cmd_ready, 1'b1);
    push(1'b1, 2'd0, 32'h0);
    check("full ready at 4", cmd_ready, 1'b0);
    push(1'b1, 2'd1, 32'h0);
    check("full still full", cmd_ready, 1'b0);
    check("full fetch_busy", fetch_busy, 1'b1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst fetch_busy", fetch_busy, 1'b0);
    check("rst loaded", sub_loaded, 4'b0000);
    check("rst busy", sub_busy, 4'b0000);
    check("rst ready", cmd_ready, 1'b1);
    check("rst idle", idle, 1'b1);
    check("rst eu_fetch", eu_fetch, 1'b0);
    check("rst eu_exec", eu_exec, 1'b0);
    check("rst err", err_unloaded, 1'b0);
    fetch_done = 1'b1; tick(); fetch_done = 1'b0;
    check("stray done loaded", sub_loaded, 4'b0000);
    check("stray done fetch_busy", fetch_busy, 1'b0);
    tick();
    tick();
    check("post rst no fetch", eu_fetch, 1'b0);
    check("post rst idle", idle, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
